ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Parametrised PS/2 host-to-device transmitter. Implements the full host request-to-send sequence: clock inhibit, start bit, device-clocked data/parity/stop shifting, ACK check and timeout supervision. Drives open-drain PS/2 lines through drive-low enables and sits beside the PS/2 receive path under the Wishbone PS/2 controller. Reports per-frame parity, done and error status.

Parameters:
DATA_W, 8, payload bits per frame (LSB first)
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (≥100 µs at system clock)
TIMEOUT_CYCLES, 50000, max clk cycles between device clock falling edges (also bounds the wait for the first edge)
SYNC_STAGES, 2, synchroniser depth on ps2_clk_i/ps2_data_i (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  request to send; sampled only in IDLE
data_i  in  DATA_W  payload; latched on accepted start
ps2_clk_i  in  1  PS/2 clock line level
ps2_data_i  in  1  PS/2 data line level
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low
busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse on successful ACK
err  out  1  one-cycle pulse on timeout or NACK
status  out  8  [0] parity sent, [1] error, [2] done, [3] timeout, [4] nack, [7:5] 0

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, status=0x00, counters cleared. Reset mid-frame releases both lines on the same edge.
- Inputs pass SYNC_STAGES flops; falling edge of the device clock = synced prev 1, current 0.
- Parity is odd: par = ~^data (computed on latched data).
- IDLE: start=1 -> latch data, compute par, clear status, busy=1, go INHIBIT. start while busy is ignored.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles -> RTS.
- RTS: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0 the same cycle -> SHIFT with bit index 0 and timeout counter cleared.
- SHIFT: on falling edge k (1..DATA_W): ps2_data_oe = ~data[k-1]. Edge DATA_W+1: ps2_data_oe = ~par. Edge DATA_W+2: ps2_data_oe=0 (stop bit) -> ACK.
- ACK: on next falling edge, sample synced data: 0 -> WAIT_REL; 1 -> NACK error.
- WAIT_REL: wait until synced clk=1 and data=1 -> DONE.
- DONE: done=1 for one cycle, status[2]=1, status[0]=par, busy=0 -> IDLE.
- Timeout: in RTS/SHIFT/ACK/WAIT_REL, the counter increments each cycle and clears on each device falling edge. Reaching TIMEOUT_CYCLES -> both oe=0, err pulse, status[1]=1, status[3]=1, busy=0 -> IDLE.
- NACK: both oe=0, err pulse, status[1]=1, status[4]=1 -> IDLE.
- status is sticky until the next accepted start or reset.
- done and err are never high together.

Decomposition:
- Shared package ps2_pkg: state encoding (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_REL, DONE), status bit index constants, odd-parity function.
- Sub-module ps2_sync_edge (SYNC_STAGES param): synchroniser plus falling-edge detect. It is reused by the receive path.

Test Plan:
- data_i=0xED, device model clocks at 12.5 kHz and ACKs -> wire bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulse; status=0x05.
- data_i=0x01, then 0xFF, then 0x00 -> parity bits 0, 1, 1; status[0] matches per frame.
- Device never clocks after RTS -> err at TIMEOUT_CYCLES after RTS; status=0x0A; both oe=0; busy=0.
- Device leaves data high at ACK edge -> err pulse; status=0x12; lines released.
- start pulsed during SHIFT -> ignored, frame unchanged. rst=0 mid-SHIFT -> next cycle both oe=0, status=0x00, busy=0.
- Count ps2_clk_oe high duration with INHIBIT_CYCLES=16 -> exactly 16 cycles. ps2_data_oe rises in the cycle ps2_clk_oe falls.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module  : ps2_pkg
//  Brief   : Shared PS/2 host definitions: FSM encoding, status bits, parity.
//  Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_RTS      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_REL = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  localparam int STAT_PAR     = 0;
  localparam int STAT_ERR     = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_NACK    = 4;

  // Zero-extension does not change parity, so one width serves every frame size.
  function automatic logic odd_parity(input logic [63:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ============================================================================
//  Module  : ps2_sync_edge
//  Brief   : PS/2 line synchroniser with device-clock falling-edge detect.
//  Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_clk_fall
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;

  // Idle PS/2 lines float high; resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign o_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign o_data_s   = r_data_sync[SYNC_STAGES-1];
  assign o_clk_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
//  Module  : ps2_host_tx
//  Brief   : PS/2 host-to-device transmitter (inhibit, RTS, shift, ACK, timeout).
//  Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        status
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_W + 3);

  localparam logic [IW-1:0] c_INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] c_BIT_PAR  = BW'(DATA_W);
  localparam logic [BW-1:0] c_BIT_STOP = BW'(DATA_W + 1);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [IW-1:0]     r_inh;
  logic [TW-1:0]     r_to;
  logic [BW-1:0]     r_bit;
  logic              r_drv;
  logic [7:0]        r_status;

  logic w_clk_s;
  logic w_data_s;
  logic w_clk_fall;
  logic w_counting;
  logic w_timeout;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk_i),
    .i_ps2_data (ps2_data_i),
    .o_clk_s    (w_clk_s),
    .o_data_s   (w_data_s),
    .o_clk_fall (w_clk_fall)
  );

  assign w_counting = (r_state == ST_RTS) || (r_state == ST_SHIFT) ||
                      (r_state == ST_ACK) || (r_state == ST_WAIT_REL);
  assign w_timeout  = w_counting && !w_clk_fall && (r_to == c_TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_INHIBIT;
      ST_INHIBIT:  if (r_inh == c_INH_LAST) w_next = ST_RTS;
      ST_RTS:      w_next = ST_SHIFT;
      ST_SHIFT:    if (w_clk_fall && (r_bit == c_BIT_STOP)) w_next = ST_ACK;
      ST_ACK:      if (w_clk_fall) w_next = w_data_s ? ST_ERR : ST_WAIT_REL;
      ST_WAIT_REL: if (w_clk_s && w_data_s) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      ST_ERR:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_ERR;
  end

  always_comb begin
    ps2_clk_oe  = (r_state == ST_INHIBIT);
    ps2_data_oe = (r_state == ST_RTS) || ((r_state == ST_SHIFT) && r_drv);
    busy        = (r_state == ST_INHIBIT) || w_counting;
    done        = (r_state == ST_DONE);
    err         = (r_state == ST_ERR);
    status      = r_status;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_inh    <= '0;
      r_to     <= '0;
      r_bit    <= '0;
      r_drv    <= 1'b0;
      r_status <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift  <= data_i;
            r_par    <= odd_parity(64'(data_i));
            r_inh    <= '0;
            r_status <= '0;
          end
        end
        ST_INHIBIT: begin
          r_inh <= r_inh + IW'(1);
          r_to  <= '0;
          r_bit <= '0;
          r_drv <= 1'b1;
        end
        ST_SHIFT: begin
          // The start bit is already on the wire; each edge presents the next bit.
          if (w_clk_fall) begin
            r_bit <= r_bit + BW'(1);
            if (r_bit < c_BIT_PAR) begin
              r_drv   <= ~r_shift[0];
              r_shift <= r_shift >> 1;
            end else if (r_bit == c_BIT_PAR) begin
              r_drv <= ~r_par;
            end else begin
              r_drv <= 1'b0;
            end
          end
        end
        default: ;
      endcase

      if (w_counting) r_to <= w_clk_fall ? '0 : r_to + TW'(1);

      if (w_next == ST_DONE) begin
        r_status[STAT_DONE] <= 1'b1;
        r_status[STAT_PAR]  <= r_par;
      end
      if (w_next == ST_ERR) begin
        r_status[STAT_ERR] <= 1'b1;
        if (w_timeout) r_status[STAT_TIMEOUT] <= 1'b1;
        else           r_status[STAT_NACK]    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
